// File: rtl/cache_sim_pkg.sv
// ----------------------------------------------------------------------------
// cache_sim_pkg : shared command codes and dispatcher state encoding
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cache_sim_pkg;

  localparam int DEFAULT_ADDR_BITS = 32;
  localparam int CMD_BITS          = 4;

  localparam logic [3:0] CMD_READ       = 4'd0;
  localparam logic [3:0] CMD_WRITE      = 4'd1;
  localparam logic [3:0] CMD_IFETCH     = 4'd2;
  localparam logic [3:0] CMD_INVALIDATE = 4'd3;
  localparam logic [3:0] CMD_SNOOP      = 4'd4;
  localparam logic [3:0] CMD_RESET      = 4'd8;
  localparam logic [3:0] CMD_PRINT      = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE_D    = 3'd1,
    ST_ISSUE_I    = 3'd2,
    ST_ISSUE_BOTH = 3'd3,
    ST_PRINT      = 3'd4,
    ST_DONE       = 3'd5
  } disp_state_t;

  // ST_IDLE doubles as the "illegal code" answer: such commands are dropped.
  function automatic disp_state_t route_cmd(input logic [3:0] code);
    case (code)
      CMD_READ, CMD_WRITE, CMD_INVALIDATE, CMD_SNOOP: return ST_ISSUE_D;
      CMD_IFETCH:                                     return ST_ISSUE_I;
      CMD_RESET:                                      return ST_ISSUE_BOTH;
      CMD_PRINT:                                      return ST_PRINT;
      default:                                        return ST_IDLE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_fifo.sv
// ----------------------------------------------------------------------------
// cmd_fifo : synchronous FIFO with full/empty flags and occupancy count
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int                  PTR_BITS   = $clog2(DEPTH);
  localparam logic [PTR_BITS:0]   FULL_COUNT = (PTR_BITS+1)'(DEPTH);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [PTR_BITS-1:0] r_wr_ptr;
  logic [PTR_BITS-1:0] r_rd_ptr;
  logic [PTR_BITS:0]   r_count;
  logic                w_do_push;
  logic                w_do_pop;

  assign w_do_push = i_push && (r_count != FULL_COUNT);
  assign w_do_pop  = i_pop  && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == FULL_COUNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/trace_dispatcher.sv
// ----------------------------------------------------------------------------
// trace_dispatcher : buffers trace commands and issues them in order to caches
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module trace_dispatcher
  import cache_sim_pkg::*;
#(
  parameter int ADDR_BITS  = DEFAULT_ADDR_BITS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic                 trace_end,
  output logic                 dc_req,
  output logic [3:0]           dc_cmd,
  output logic [ADDR_BITS-1:0] dc_addr,
  input  logic                 dc_ack,
  output logic                 ic_req,
  output logic [3:0]           ic_cmd,
  output logic [ADDR_BITS-1:0] ic_addr,
  input  logic                 ic_ack,
  output logic                 print_req,
  output logic                 done,
  output logic [15:0]          illegal_cnt,
  output logic                 busy
);

  localparam int ENTRY_BITS = CMD_BITS + ADDR_BITS;

  disp_state_t                r_state;
  disp_state_t                w_state_nxt;
  logic                       r_end_flag;

  logic                       r_dc_req;
  logic [3:0]                 r_dc_cmd;
  logic [ADDR_BITS-1:0]       r_dc_addr;
  logic                       r_ic_req;
  logic [3:0]                 r_ic_cmd;
  logic [ADDR_BITS-1:0]       r_ic_addr;
  logic                       r_print_req;
  logic                       r_done;
  logic [15:0]                r_illegal_cnt;

  logic                       w_dc_req_nxt;
  logic [3:0]                 w_dc_cmd_nxt;
  logic [ADDR_BITS-1:0]       w_dc_addr_nxt;
  logic                       w_ic_req_nxt;
  logic [3:0]                 w_ic_cmd_nxt;
  logic [ADDR_BITS-1:0]       w_ic_addr_nxt;
  logic                       w_print_req_nxt;
  logic                       w_done_nxt;
  logic [15:0]                w_illegal_cnt_nxt;

  logic                       w_push;
  logic                       w_pop;
  logic [ENTRY_BITS-1:0]      w_fifo_rdata;
  logic                       w_fifo_full;
  logic                       w_fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
  logic [3:0]                 w_head_cmd;
  logic [ADDR_BITS-1:0]       w_head_addr;
  disp_state_t                w_head_route;

  assign cmd_ready = !w_fifo_full && !r_end_flag && (r_state != ST_DONE);
  assign w_push    = cmd_valid && cmd_ready;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_BITS)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (w_push),
    .i_wdata ({cmd, cmd_addr}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_head_cmd   = w_fifo_rdata[ENTRY_BITS-1 -: CMD_BITS];
  assign w_head_addr  = w_fifo_rdata[ADDR_BITS-1:0];
  assign w_head_route = route_cmd(w_head_cmd);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_end_flag    <= 1'b0;
      r_dc_req      <= 1'b0;
      r_dc_cmd      <= '0;
      r_dc_addr     <= '0;
      r_ic_req      <= 1'b0;
      r_ic_cmd      <= '0;
      r_ic_addr     <= '0;
      r_print_req   <= 1'b0;
      r_done        <= 1'b0;
      r_illegal_cnt <= '0;
    end else begin
      r_state       <= w_state_nxt;
      if (trace_end) begin
        r_end_flag <= 1'b1;
      end
      r_dc_req      <= w_dc_req_nxt;
      r_dc_cmd      <= w_dc_cmd_nxt;
      r_dc_addr     <= w_dc_addr_nxt;
      r_ic_req      <= w_ic_req_nxt;
      r_ic_cmd      <= w_ic_cmd_nxt;
      r_ic_addr     <= w_ic_addr_nxt;
      r_print_req   <= w_print_req_nxt;
      r_done        <= w_done_nxt;
      r_illegal_cnt <= w_illegal_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_pop             = 1'b0;
    w_dc_req_nxt      = r_dc_req;
    w_dc_cmd_nxt      = r_dc_cmd;
    w_dc_addr_nxt     = r_dc_addr;
    w_ic_req_nxt      = r_ic_req;
    w_ic_cmd_nxt      = r_ic_cmd;
    w_ic_addr_nxt     = r_ic_addr;
    w_print_req_nxt   = 1'b0;
    w_done_nxt        = r_done;
    w_illegal_cnt_nxt = r_illegal_cnt;

    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = w_head_route;
          case (w_head_route)
            ST_ISSUE_D: begin
              w_dc_req_nxt  = 1'b1;
              w_dc_cmd_nxt  = w_head_cmd;
              w_dc_addr_nxt = w_head_addr;
            end
            ST_ISSUE_I: begin
              w_ic_req_nxt  = 1'b1;
              w_ic_cmd_nxt  = w_head_cmd;
              w_ic_addr_nxt = w_head_addr;
            end
            ST_ISSUE_BOTH: begin
              w_dc_req_nxt  = 1'b1;
              w_dc_cmd_nxt  = w_head_cmd;
              w_dc_addr_nxt = w_head_addr;
              w_ic_req_nxt  = 1'b1;
              w_ic_cmd_nxt  = w_head_cmd;
              w_ic_addr_nxt = w_head_addr;
            end
            ST_PRINT: begin
              w_print_req_nxt = 1'b1;
            end
            default: begin
              w_state_nxt = ST_IDLE;
              if (r_illegal_cnt != 16'hFFFF) begin
                w_illegal_cnt_nxt = r_illegal_cnt + 16'd1;
              end
            end
          endcase
        end else if (r_end_flag) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end
      end

      ST_ISSUE_D: begin
        if (dc_ack) begin
          w_dc_req_nxt = 1'b0;
          w_state_nxt  = ST_IDLE;
        end
      end

      ST_ISSUE_I: begin
        if (ic_ack) begin
          w_ic_req_nxt = 1'b0;
          w_state_nxt  = ST_IDLE;
        end
      end

      // Each side retires on its own ack; a late ack on a retired side is harmless.
      ST_ISSUE_BOTH: begin
        if (dc_ack) begin
          w_dc_req_nxt = 1'b0;
        end
        if (ic_ack) begin
          w_ic_req_nxt = 1'b0;
        end
        if (!w_dc_req_nxt && !w_ic_req_nxt) begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_PRINT: begin
        w_state_nxt = ST_IDLE;
      end

      ST_DONE: begin
        w_state_nxt = ST_DONE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign dc_req      = r_dc_req;
  assign dc_cmd      = r_dc_cmd;
  assign dc_addr     = r_dc_addr;
  assign ic_req      = r_ic_req;
  assign ic_cmd      = r_ic_cmd;
  assign ic_addr     = r_ic_addr;
  assign print_req   = r_print_req;
  assign done        = r_done;
  assign illegal_cnt = r_illegal_cnt;
  assign busy        = ((r_state != ST_IDLE) && (r_state != ST_DONE)) || (w_fifo_count != '0);

endmodule

`default_nettype wire

// File: tb/tb_trace_dispatcher.sv
// ----------------------------------------------------------------------------
// tb_trace_dispatcher : directed and randomized checks for trace_dispatcher
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_trace_dispatcher;

  localparam int AB    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd;
  logic [AB-1:0] cmd_addr;
  logic          trace_end;
  logic          dc_req;
  logic [3:0]    dc_cmd;
  logic [AB-1:0] dc_addr;
  logic          dc_ack;
  logic          ic_req;
  logic [3:0]    ic_cmd;
  logic [AB-1:0] ic_addr;
  logic          ic_ack;
  logic          print_req;
  logic          done;
  logic [15:0]   illegal_cnt;
  logic          busy;

  always #5 clk = ~clk;

  trace_dispatcher #(.ADDR_BITS(AB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .cmd_addr(cmd_addr), .trace_end(trace_end),
    .dc_req(dc_req), .dc_cmd(dc_cmd), .dc_addr(dc_addr), .dc_ack(dc_ack),
    .ic_req(ic_req), .ic_cmd(ic_cmd), .ic_addr(ic_addr), .ic_ack(ic_ack),
    .print_req(print_req), .done(done), .illegal_cnt(illegal_cnt), .busy(busy)
  );

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  // Observed issue events and the expected sequence (target: 0=D 1=I 2=both 3=print)
  int          ev_tgt[$];
  int          ev_cmd[$];
  int          ev_cyc[$];
  logic [31:0] ev_addr[$];
  int          ex_tgt[$];
  int          ex_cmd[$];
  logic [31:0] ex_addr[$];
  int          exp_illegal = 0;

  logic prev_dc = 1'b0, prev_ic = 1'b0, prev_pr = 1'b0;
  int   dc_hi = 0, ic_hi = 0, pr_hi = 0, order_viol = 0, ic_fall_cyc = 0;

  bit hold = 1'b0, rnd_dly = 1'b0, spur = 1'b0;
  int d_dly = 1, i_dly = 1, d_cnt = -1, i_cnt = -1;

  int codes[7] = '{0, 1, 2, 3, 4, 8, 9};
  int cache_codes[6] = '{0, 1, 2, 3, 4, 8};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int tgt_of(input int code);
    if (code == 0 || code == 1 || code == 3 || code == 4) return 0;
    if (code == 2) return 1;
    if (code == 8) return 2;
    if (code == 9) return 3;
    return -1;
  endfunction

  task automatic model_push(input int code, input logic [31:0] addr);
    int t;
    t = tgt_of(code);
    if (t < 0) begin
      if (exp_illegal < 65535) exp_illegal++;
    end else begin
      ex_tgt.push_back(t);
      ex_cmd.push_back(code);
      ex_addr.push_back((t == 3) ? 32'd0 : addr);
    end
  endtask

  task automatic log_ev(input int t, input int c, input logic [31:0] a);
    ev_tgt.push_back(t);
    ev_cmd.push_back(c);
    ev_addr.push_back(a);
    ev_cyc.push_back(cyc);
  endtask

  task automatic observe();
    cyc++;
    if (dc_req) dc_hi++;
    if (ic_req) ic_hi++;
    if (print_req) pr_hi++;
    if (dc_req && !prev_dc && ic_req && !prev_ic) begin
      log_ev(2, int'(dc_cmd), dc_addr);
    end else begin
      if (dc_req && !prev_dc) begin
        if (prev_ic || ic_req) order_viol++;
        log_ev(0, int'(dc_cmd), dc_addr);
      end
      if (ic_req && !prev_ic) begin
        if (prev_dc || dc_req) order_viol++;
        log_ev(1, int'(ic_cmd), ic_addr);
      end
    end
    if (print_req && !prev_pr) begin
      if (dc_req || ic_req) order_viol++;
      log_ev(3, 9, 32'd0);
    end
    if (prev_ic && !ic_req) ic_fall_cyc = cyc;
    prev_dc = dc_req;
    prev_ic = ic_req;
    prev_pr = print_req;
  endtask

  // Cache stand-ins: ack a fixed or random number of cycles after req rises.
  task automatic respond();
    dc_ack = 1'b0;
    ic_ack = 1'b0;
    if (!dc_req) begin
      d_cnt = -1;
      if (spur && $urandom_range(0, 3) == 0) dc_ack = 1'b1;
    end else if (!hold) begin
      if (d_cnt == -1) d_cnt = rnd_dly ? int'($urandom_range(0, 3)) : d_dly;
      if (d_cnt == 0) begin
        dc_ack = 1'b1;
        d_cnt  = -2;
      end else if (d_cnt > 0) begin
        d_cnt--;
      end
    end
    if (!ic_req) begin
      i_cnt = -1;
      if (spur && $urandom_range(0, 3) == 0) ic_ack = 1'b1;
    end else if (!hold) begin
      if (i_cnt == -1) i_cnt = rnd_dly ? int'($urandom_range(0, 3)) : i_dly;
      if (i_cnt == 0) begin
        ic_ack = 1'b1;
        i_cnt  = -2;
      end else if (i_cnt > 0) begin
        i_cnt--;
      end
    end
  endtask

  task automatic tick();
    if (cmd_valid && cmd_ready) model_push(int'(cmd), cmd_addr);
    @(posedge clk);
    #1;
    observe();
    respond();
  endtask

  task automatic clear_logs();
    ev_tgt.delete(); ev_cmd.delete(); ev_addr.delete(); ev_cyc.delete();
    ex_tgt.delete(); ex_cmd.delete(); ex_addr.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b1;
    #1;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    trace_end = 1'b0;
    dc_ack    = 1'b0;
    ic_ack    = 1'b0;
    #1;
    chk("rst_flags", {59'd0, dc_req, ic_req, print_req, done, busy}, 64'd0);
    chk("rst_illegal", illegal_cnt, 64'd0);
    chk("rst_dc_bus", {dc_cmd, dc_addr}, 64'd0);
    chk("rst_ic_bus", {ic_cmd, ic_addr}, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    prev_dc = 1'b0; prev_ic = 1'b0; prev_pr = 1'b0;
    d_cnt = -1; i_cnt = -1;
    exp_illegal = 0;
    clear_logs();
    #1;
    chk("rst_ready", cmd_ready, 64'd1);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    cmd_valid = 1'b0;
    tick();
    tick();
    while ((busy || dc_req || ic_req) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_drain_timeout"}, {63'd0, (n >= budget)}, 64'd0);
  endtask

  task automatic compare_log(input string tag);
    chk({tag, "_nevents"}, ev_tgt.size(), ex_tgt.size());
    for (int i = 0; i < ev_tgt.size() && i < ex_tgt.size(); i++) begin
      chk($sformatf("%s_tgt%0d", tag, i), ev_tgt[i], ex_tgt[i]);
      chk($sformatf("%s_cmd%0d", tag, i), ev_cmd[i], ex_cmd[i]);
      chk($sformatf("%s_addr%0d", tag, i), ev_addr[i], ex_addr[i]);
    end
    clear_logs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit acc_now;
    int arr[6];
    reset_n = 1'b1; cmd_valid = 1'b0; cmd = 4'd0; cmd_addr = '0;
    trace_end = 1'b0; dc_ack = 1'b0; ic_ack = 1'b0;
    do_reset();

    // READ 0x1000, ack two cycles after req
    d_dly = 2; i_dly = 1; dc_hi = 0; ic_hi = 0;
    cmd_valid = 1'b1; cmd = 4'd0; cmd_addr = 32'h0000_1000;
    tick();
    cmd_valid = 1'b0;
    chk("t1_req_cycle1", dc_req, 64'd0);
    chk("t1_busy", busy, 64'd1);
    tick();
    chk("t1_req_cycle2", dc_req, 64'd1);
    chk("t1_dc_cmd", dc_cmd, 64'd0);
    chk("t1_dc_addr", dc_addr, 64'h1000);
    drain("t1", 20);
    chk("t1_req_high_cycles", dc_hi, 64'd3);
    chk("t1_ic_never", ic_hi, 64'd0);
    compare_log("t1");

    // IFETCH then WRITE back-to-back, single-cycle acks
    d_dly = 1; i_dly = 1;
    cmd_valid = 1'b1; cmd = 4'd2; cmd_addr = 32'h40;
    tick();
    cmd = 4'd1; cmd_addr = 32'h80;
    tick();
    cmd_valid = 1'b0;
    drain("t2", 30);
    chk("t2_nev", ev_cyc.size(), 64'd2);
    if (ev_cyc.size() >= 2) begin
      chk("t2_throughput", ev_cyc[1] - ev_cyc[0], 64'd3);
      chk("t2_dc_after_ic_fall", {63'd0, ev_cyc[1] > ic_fall_cyc}, 64'd1);
    end
    compare_log("t2");

    // RESET to both caches, ic acks after 1, dc after 4, READ queued behind it
    d_dly = 4; i_dly = 1; dc_hi = 0; ic_hi = 0;
    cmd_valid = 1'b1; cmd = 4'd8; cmd_addr = 32'hABC0;
    tick();
    cmd = 4'd0; cmd_addr = 32'h200;
    tick();
    cmd_valid = 1'b0;
    chk("t3_both_rise", {dc_req, ic_req}, 64'd3);
    chk("t3_ic_bus", {ic_cmd, ic_addr}, {28'd0, 4'd8, 32'hABC0});
    drain("t3", 40);
    chk("t3_nev", ev_cyc.size(), 64'd2);
    if (ev_cyc.size() >= 2) begin
      chk("t3_next_pop_gap", ev_cyc[1] - ev_cyc[0], 64'd6);
      chk("t3_ic_fall", ic_fall_cyc - ev_cyc[0], 64'd2);
    end
    chk("t3_dc_hi", dc_hi, 64'd10);
    chk("t3_ic_hi", ic_hi, 64'd2);
    compare_log("t3");

    // Fill with acks held: 5 accepts (1 in flight + 4 queued), then release
    hold = 1'b1;
    for (int i = 0; i < 6; i++) arr[i] = cache_codes[$urandom_range(0, 5)];
    k = 0;
    for (int c = 0; c < 12 && k < 6; c++) begin
      cmd_valid = 1'b1;
      cmd       = 4'(arr[k]);
      if (c == 0 || acc_now) cmd_addr = $urandom;
      acc_now = cmd_ready;
      tick();
      if (acc_now) k++;
    end
    cmd_valid = 1'b0;
    chk("t4_accepts", k, 64'd5);
    chk("t4_ready_low", cmd_ready, 64'd0);
    hold = 1'b0; rnd_dly = 1'b1;
    drain("t4", 200);
    compare_log("t4");

    // Two illegal codes then PRINT
    pr_hi = 0; dc_hi = 0; ic_hi = 0;
    cmd_valid = 1'b1; cmd = 4'd5; cmd_addr = 32'h1;
    tick();
    cmd = 4'd15;
    tick();
    cmd = 4'd9;
    tick();
    cmd_valid = 1'b0;
    drain("t5", 20);
    chk("t5_illegal_cnt", illegal_cnt, exp_illegal);
    chk("t5_illegal_two", illegal_cnt, 64'd2);
    chk("t5_print_cycles", pr_hi, 64'd1);
    chk("t5_no_cache_req", dc_hi + ic_hi, 64'd0);
    compare_log("t5");

    // Reset while a request is held: req must drop at once
    hold = 1'b1; rnd_dly = 1'b0;
    cmd_valid = 1'b1; cmd = 4'd0; cmd_addr = 32'h3000;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("t7_req_held", dc_req, 64'd1);
    do_reset();
    hold = 1'b0;
    tick();
    tick();
    chk("t7_in_flight_lost", {62'd0, dc_req, busy}, 64'd0);
    clear_logs();

    // Randomized traffic against the ordered reference
    rnd_dly = 1'b1; spur = 1'b1; order_viol = 0; acc_now = 1'b1;
    for (int n = 0; n < 80; n++) begin
      if (!cmd_valid || acc_now) begin
        cmd_valid = ($urandom_range(0, 3) != 0);
        cmd       = ($urandom_range(0, 3) != 0) ? 4'(codes[$urandom_range(0, 6)]) : 4'($urandom_range(0, 15));
        cmd_addr  = $urandom;
      end
      acc_now = cmd_valid && cmd_ready;
      tick();
    end
    drain("rnd", 600);
    chk("rnd_illegal_cnt", illegal_cnt, exp_illegal);
    chk("rnd_order", order_viol, 64'd0);
    compare_log("rnd");

    // SNOOP accepted in the same cycle as trace_end, then DONE
    rnd_dly = 1'b0; spur = 1'b0; d_dly = 1;
    cmd_valid = 1'b1; cmd = 4'd4; cmd_addr = 32'h5500; trace_end = 1'b1;
    tick();
    cmd_valid = 1'b0; trace_end = 1'b0;
    chk("t6_ready_after_end", cmd_ready, 64'd0);
    drain("t6", 20);
    tick();
    tick();
    chk("t6_done", done, 64'd1);
    chk("t6_busy", busy, 64'd0);
    chk("t6_ready_done", cmd_ready, 64'd0);
    compare_log("t6");
    do_reset();
    chk("t6_done_cleared", done, 64'd0);
    chk("t6_illegal_cleared", illegal_cnt, 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

`default_nettype wire
